alu_8bit: RTL and testbench

- 8-bit registered ALU with arithmetic, logic, shift/rotate and transfer operations, selected by a 4-bit opcode S plus carry-in Cin.
- Drives an 8-bit result D, zero flag Z and carry flag Cout.
- Datapath building block; the result and flags are registered once per clock.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_adder8.sv | 23 ++
 rtl/alu_8bit.sv | 90 +++++++++
 tb/tb_alu_8bit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the 8-bit registered ALU.
// The opcode encoding is shared by the top level and the testbench.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_INC  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUBB = 4'b0010,
    OP_DEC  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_NOT  = 4'b0111,
    OP_SHL  = 4'b1000,
    OP_SHR  = 4'b1001,
    OP_ROL  = 4'b1010,
    OP_ROR  = 4'b1011,
    OP_TFB  = 4'b1100,
    OP_NAND = 4'b1101,
    OP_NOR  = 4'b1110,
    OP_XNOR = 4'b1111
  } alu_op_t;

endpackage

// File: rtl/alu_adder8.sv
// 8-bit ripple-carry adder used by every arithmetic opcode of the ALU.
module alu_adder8 (
  input  logic [7:0] A,
  input  logic [7:0] Y,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  logic carry;

  // The carry ripples through a scalar so each stage sees the previous stage's carry-out.
  always_comb begin
    Sum   = 8'h00;
    carry = Cin;
    for (int i = 0; i < 8; i++) begin
      Sum[i] = A[i] ^ Y[i] ^ carry;
      carry  = (A[i] & Y[i]) | (carry & (A[i] ^ Y[i]));
    end
    Cout = carry;
  end

endmodule

// File: rtl/alu_8bit.sv
// 8-bit ALU: arithmetic, logic, shift/rotate and transfer ops with the
// result, zero flag and carry flag registered once per clock.
module alu_8bit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  input  logic [3:0] S,
  output logic [7:0] D,
  output logic       Z,
  output logic       Cout
);

  logic [7:0] addy;
  logic [7:0] sum;
  logic       sumc;
  logic [7:0] result;
  logic       carry;

  // The low opcode bits pick the adder's second operand: 0, B, ~B or all-ones.
  always_comb begin
    addy = 8'h00;
    case (S[1:0])
      2'b00: addy = 8'h00;
      2'b01: addy = B;
      2'b10: addy = ~B;
      2'b11: addy = 8'hFF;
    endcase
  end

  alu_adder8 u_adder (
    .A   (A),
    .Y   (addy),
    .Cin (Cin),
    .Sum (sum),
    .Cout(sumc)
  );

  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    case (alu_op_t'(S))
      OP_INC, OP_ADD, OP_SUBB, OP_DEC: begin
        result = sum;
        carry  = sumc;
      end
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOT:  result = ~A;
      OP_SHL: begin
        result = {A[6:0], Cin};
        carry  = A[7];
      end
      OP_SHR: begin
        result = {Cin, A[7:1]};
        carry  = A[0];
      end
      OP_ROL: begin
        result = {A[6:0], A[7]};
        carry  = A[7];
      end
      OP_ROR: begin
        result = {A[0], A[7:1]};
        carry  = A[0];
      end
      OP_TFB:  result = B;
      OP_NAND: result = ~(A & B);
      OP_NOR:  result = ~(A | B);
      OP_XNOR: result = ~(A ^ B);
    endcase
  end

  // Reset state keeps Z consistent with the cleared result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D    <= 8'h00;
      Z    <= 1'b1;
      Cout <= 1'b0;
    end else begin
      D    <= result;
      Z    <= (result == 8'h00);
      Cout <= carry;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector testbench for alu_8bit with hand-computed expectations.
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [3:0] S;
  logic [7:0] D;
  logic       Z;
  logic       Cout;
  logic       clkRun;

  int vectors;
  int miscompares;

  alu_8bit dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Cin (Cin),
    .S   (S),
    .D   (D),
    .Z   (Z),
    .Cout(Cout)
  );

  // The clock stays idle until the bench enables it, so reset can be shown to act without edges.
  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] expD,
                             input logic expZ, input logic expC);
    vectors++;
    assert ({D, Z, Cout} === {expD, expZ, expC})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: actual D=%h Z=%b Cout=%b, required D=%h Z=%b Cout=%b",
             tag, D, Z, Cout, expD, expZ, expC);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic [3:0] s);
    A   = a;
    B   = b;
    Cin = cin;
    S   = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk    = 1'b0;
    clkRun = 1'b0;
    rst    = 1'b0;
    A      = 8'h00;
    B      = 8'h00;
    Cin    = 1'b0;
    S      = 4'h0;

    #1 rst = 1'b1;
    #1 checkOutput("reset_idle_clk", 8'h00, 1'b1, 1'b0);

    A = 8'h03; B = 8'h04; Cin = 1'b0; S = 4'b0000;
    #2 rst = 1'b0;
    clkRun = 1'b1;
    applyStimulus(8'h03, 8'h04, 1'b0, 4'b0000);
    checkOutput("inc_cin0", 8'h03, 1'b0, 1'b0);

    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0000); checkOutput("inc_cin1",  8'h04, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0, 4'b0001); checkOutput("add_cin0",  8'h07, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0001); checkOutput("add_cin1",  8'h08, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0, 4'b0010); checkOutput("subb_cin0", 8'hFE, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0010); checkOutput("subb_cin1", 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0, 4'b0011); checkOutput("dec_cin0",  8'h02, 1'b0, 1'b1);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0011); checkOutput("dec_cin1",  8'h03, 1'b0, 1'b1);

    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0100); checkOutput("and",  8'h00, 1'b1, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0101); checkOutput("or",   8'h07, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0, 4'b0110); checkOutput("xor",  8'h07, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0111); checkOutput("not",  8'hFC, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0, 4'b1101); checkOutput("nand", 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b1110); checkOutput("nor",  8'hF8, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0, 4'b1111); checkOutput("xnor", 8'hF8, 1'b0, 1'b0);
    applyStimulus(8'hA5, 8'h3C, 1'b0, 4'b0110); checkOutput("xor_alt", 8'h99, 1'b0, 1'b0);

    applyStimulus(8'h03, 8'h04, 1'b0, 4'b1011); checkOutput("ror",     8'h81, 1'b0, 1'b1);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b1000); checkOutput("shl",     8'h07, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b1001); checkOutput("shr",     8'h81, 1'b0, 1'b1);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b1010); checkOutput("rol",     8'h06, 1'b0, 1'b0);
    applyStimulus(8'h81, 8'h04, 1'b0, 4'b1010); checkOutput("rol_msb", 8'h03, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h04, 1'b0, 4'b1000); checkOutput("shl_out", 8'h00, 1'b1, 1'b1);
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b1100); checkOutput("tfb",     8'h04, 1'b0, 1'b0);

    applyStimulus(8'hFF, 8'h01, 1'b0, 4'b0001); checkOutput("wrap_zero", 8'h00, 1'b1, 1'b1);
    applyStimulus(8'hFF, 8'h01, 1'b1, 4'b0001); checkOutput("wrap_one",  8'h01, 1'b0, 1'b1);
    applyStimulus(8'h00, 8'h01, 1'b0, 4'b0011); checkOutput("dec_under", 8'hFF, 1'b0, 1'b0);

    applyStimulus(8'h03, 8'h04, 1'b0, 4'b0001); checkOutput("pre_reset_add", 8'h07, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("reset_mid_cycle", 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1 checkOutput("reset_hold_edge1", 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1 checkOutput("reset_hold_edge2", 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    applyStimulus(8'h03, 8'h04, 1'b1, 4'b0001); checkOutput("first_after_reset", 8'h08, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
